// File: rtl/traffic_lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_pkg
// Description : Shared command codes, op/state enums and the command table
//               for the traffic-light configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_lights_pkg;

    localparam logic [2:0] CMD_RED_START    = 3'd0;
    localparam logic [2:0] CMD_OFF          = 3'd1;
    localparam logic [2:0] CMD_YELLOW_BLINK = 3'd2;
    localparam logic [2:0] CMD_SET_GREEN    = 3'd3;
    localparam logic [2:0] CMD_SET_RED      = 3'd4;
    localparam logic [2:0] CMD_SET_YELLOW   = 3'd5;

    typedef enum logic [1:0] {
        OP_ON       = 2'd0,
        OP_OFF      = 2'd1,
        OP_BLINK    = 2'd2,
        OP_RECONFIG = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]  ctype;
        logic [15:0] data;
    } cmd_t;

    // The light controller cannot run a zero-length phase.
    function automatic logic [15:0] clamp_ms(input logic [15:0] ms);
        return (ms == 16'd0) ? 16'd1 : ms;
    endfunction

    function automatic logic [2:0] last_step(input op_e op);
        return (op == OP_RECONFIG) ? 3'd4 : 3'd0;
    endfunction

    function automatic cmd_t cmd_lookup(input op_e         op,
                                        input logic [2:0]  step,
                                        input logic [15:0] green_ms,
                                        input logic [15:0] red_ms,
                                        input logic [15:0] yellow_ms);
        cmd_t c;
        c.ctype = CMD_RED_START;
        c.data  = 16'd0;
        case (op)
            OP_ON:    c.ctype = CMD_RED_START;
            OP_OFF:   c.ctype = CMD_OFF;
            OP_BLINK: c.ctype = CMD_YELLOW_BLINK;
            default: begin
                // Blink while reprogramming, then restart from red.
                case (step)
                    3'd0: c.ctype = CMD_YELLOW_BLINK;
                    3'd1: begin c.ctype = CMD_SET_GREEN;  c.data = clamp_ms(green_ms);  end
                    3'd2: begin c.ctype = CMD_SET_RED;    c.data = clamp_ms(red_ms);    end
                    3'd3: begin c.ctype = CMD_SET_YELLOW; c.data = clamp_ms(yellow_ms); end
                    default: c.ctype = CMD_RED_START;
                endcase
            end
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter; pointer moves on accepted grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_upd_idx,
    output logic [1:0] o_grant
);

    // 0 favours requester 0, 1 favours requester 1.
    logic r_prio;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prio <= 1'b0;
        end else if (i_update) begin
            r_prio <= ~i_upd_idx;
        end
    end

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/traffic_lights_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_cfg_seq
// Description : Arbitrates two requesters and expands each request into a
//               spaced sequence of light-controller commands.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_lights_cfg_seq
    import traffic_lights_pkg::*;
#(
    parameter int unsigned CMD_GAP_CLK = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       req_val_i,
    output logic [1:0]       req_rdy_o,
    input  logic [1:0][1:0]  req_op_i,
    input  logic [1:0][15:0] req_green_ms_i,
    input  logic [1:0][15:0] req_red_ms_i,
    input  logic [1:0][15:0] req_yellow_ms_i,
    output logic [2:0]       cmd_type_o,
    output logic             cmd_val_o,
    output logic [15:0]      cmd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o
);

    localparam logic [7:0] c_GAP_LAST = 8'(CMD_GAP_CLK - 1);

    state_e      r_state, w_state_nxt;
    logic [2:0]  r_step, w_step_nxt;
    logic [7:0]  r_gap, w_gap_nxt;
    op_e         r_op, w_op_nxt;
    logic [15:0] r_green, w_green_nxt;
    logic [15:0] r_red, w_red_nxt;
    logic [15:0] r_yellow, w_yellow_nxt;
    logic        r_id, w_id_nxt;

    logic [1:0]  r_rdy;
    logic [2:0]  r_cmd_type;
    logic        r_cmd_val;
    logic [15:0] r_cmd_data;
    logic        r_busy;
    logic        r_done;
    logic        r_done_id;

    logic [1:0]  w_grant;
    logic        w_accept;
    logic        w_acc_idx;
    cmd_t        w_cmd;

    rr_arbiter2 u_arb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_req     (req_val_i),
        .i_update  (w_accept),
        .i_upd_idx (w_acc_idx),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_accept     = |(r_rdy & req_val_i);
        w_acc_idx    = r_rdy[1];
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_gap_nxt    = r_gap;
        w_op_nxt     = r_op;
        w_green_nxt  = r_green;
        w_red_nxt    = r_red;
        w_yellow_nxt = r_yellow;
        w_id_nxt     = r_id;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ISSUE;
                    w_step_nxt   = 3'd0;
                    w_gap_nxt    = 8'd0;
                    w_op_nxt     = op_e'(req_op_i[w_acc_idx]);
                    w_green_nxt  = req_green_ms_i[w_acc_idx];
                    w_red_nxt    = req_red_ms_i[w_acc_idx];
                    w_yellow_nxt = req_yellow_ms_i[w_acc_idx];
                    w_id_nxt     = w_acc_idx;
                end
            end
            ISSUE: begin
                if (r_step == last_step(r_op)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = GAP;
                    w_step_nxt  = r_step + 3'd1;
                    w_gap_nxt   = 8'd0;
                end
            end
            GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_gap_nxt = r_gap + 8'd1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so the first command
        // appears in the cycle right after the accept.
        w_cmd = cmd_lookup(w_op_nxt, w_step_nxt, w_green_nxt, w_red_nxt, w_yellow_nxt);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_step     <= 3'd0;
            r_gap      <= 8'd0;
            r_op       <= OP_ON;
            r_green    <= 16'd0;
            r_red      <= 16'd0;
            r_yellow   <= 16'd0;
            r_id       <= 1'b0;
            r_rdy      <= 2'b00;
            r_cmd_type <= 3'd0;
            r_cmd_val  <= 1'b0;
            r_cmd_data <= 16'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_gap      <= w_gap_nxt;
            r_op       <= w_op_nxt;
            r_green    <= w_green_nxt;
            r_red      <= w_red_nxt;
            r_yellow   <= w_yellow_nxt;
            r_id       <= w_id_nxt;
            r_rdy      <= (w_state_nxt == IDLE) ? w_grant : 2'b00;
            r_cmd_val  <= (w_state_nxt == ISSUE);
            r_cmd_type <= (w_state_nxt == ISSUE) ? w_cmd.ctype : 3'd0;
            r_cmd_data <= (w_state_nxt == ISSUE) ? w_cmd.data : 16'd0;
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= (w_state_nxt == DONE);
            if (w_state_nxt == DONE) begin
                r_done_id <= r_id;
            end
        end
    end

    assign req_rdy_o  = r_rdy;
    assign cmd_type_o = r_cmd_type;
    assign cmd_val_o  = r_cmd_val;
    assign cmd_data_o = r_cmd_data;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign done_id_o  = r_done_id;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lights_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_lights_cfg_seq
// Description : Bench for traffic_lights_cfg_seq with gap 1 and gap 3 copies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_lights_cfg_seq;
    import traffic_lights_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic             rst_n [2];
    logic [1:0]       val   [2];
    logic [1:0][1:0]  op    [2];
    logic [1:0][15:0] gms   [2];
    logic [1:0][15:0] rms   [2];
    logic [1:0][15:0] yms   [2];
    logic [1:0]       rdy   [2];
    logic [2:0]       ctype [2];
    logic             cval  [2];
    logic [15:0]      cdata [2];
    logic             busy  [2];
    logic             done  [2];
    logic             did   [2];

    traffic_lights_cfg_seq #(.CMD_GAP_CLK(1)) u_dut_g1 (
        .clk_i(clk), .rst_n_i(rst_n[0]), .req_val_i(val[0]), .req_rdy_o(rdy[0]),
        .req_op_i(op[0]), .req_green_ms_i(gms[0]), .req_red_ms_i(rms[0]),
        .req_yellow_ms_i(yms[0]), .cmd_type_o(ctype[0]), .cmd_val_o(cval[0]),
        .cmd_data_o(cdata[0]), .busy_o(busy[0]), .done_o(done[0]), .done_id_o(did[0])
    );

    traffic_lights_cfg_seq #(.CMD_GAP_CLK(3)) u_dut_g3 (
        .clk_i(clk), .rst_n_i(rst_n[1]), .req_val_i(val[1]), .req_rdy_o(rdy[1]),
        .req_op_i(op[1]), .req_green_ms_i(gms[1]), .req_red_ms_i(rms[1]),
        .req_yellow_ms_i(yms[1]), .cmd_type_o(ctype[1]), .cmd_val_o(cval[1]),
        .cmd_data_o(cdata[1]), .busy_o(busy[1]), .done_o(done[1]), .done_id_o(did[1])
    );

    typedef struct {
        int          d;
        int          cyc;
        logic [2:0]  t;
        logic [15:0] dat;
    } pulse_t;

    typedef struct {
        int   d;
        int   cyc;
        logic id;
    } done_t;

    pulse_t pq[$];
    done_t  dq[$];

    // Round-robin model: the requester granted last loses a tie.
    int last_k [2] = '{1, 1};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pulse_t p;
            done_t  q;
            tests++;
            assert ((cval[d] === 1'b1) || ({ctype[d], cdata[d]} === 19'd0)) else begin
                fails++;
                $error("FAIL idle_cmd dut%0d cyc%0d: observed type=%0d data=%0h, expected 0/0", d, cyc, ctype[d], cdata[d]);
            end
            tests++;
            assert ($onehot0(rdy[d])) else begin
                fails++;
                $error("FAIL rdy_onehot dut%0d cyc%0d: observed %b, expected at most one bit", d, cyc, rdy[d]);
            end
            if (cval[d] === 1'b1) begin
                p.d = d; p.cyc = cyc; p.t = ctype[d]; p.dat = cdata[d];
                pq.push_back(p);
            end
            if (done[d] === 1'b1) begin
                q.d = d; q.cyc = cyc; q.id = did[d];
                dq.push_back(q);
            end
        end
    end

    function automatic int gap_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int n_cmds(input logic [1:0] o);
        return (o == 2'd3) ? 5 : 1;
    endfunction

    function automatic logic [15:0] fix_ms(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    function automatic logic [18:0] exp_cmd(input logic [1:0] o, input int i,
                                            input logic [15:0] g, input logic [15:0] r,
                                            input logic [15:0] y);
        if (o != 2'd3) return {1'b0, o, 16'd0};
        case (i)
            0:       return {3'd2, 16'd0};
            1:       return {3'd3, fix_ms(g)};
            2:       return {3'd4, fix_ms(r)};
            3:       return {3'd5, fix_ms(y)};
            default: return {3'd0, 16'd0};
        endcase
    endfunction

    function automatic int done_cyc(input int d, input logic [1:0] o, input int acc);
        return acc + 1 + (n_cmds(o) - 1) * (gap_of(d) + 1) + 1;
    endfunction

    function automatic logic [15:0] rnd_ms();
        case ($urandom % 4)
            0:       return 16'd0;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_req(input int d, input int k, input logic [1:0] o,
                           input logic [15:0] g, input logic [15:0] r, input logic [15:0] y);
        op[d][k] = o; gms[d][k] = g; rms[d][k] = r; yms[d][k] = y;
    endtask

    task automatic wait_accept(input int d, input int exp_k, input int exp_cyc,
                               output int k, output int acc);
        bit found = 1'b0;
        k = 0;
        acc = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if ((rdy[d] & val[d]) != 2'b00) begin
                found = 1'b1;
                k = rdy[d][1] ? 1 : 0;
                acc = cyc;
            end
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL accept_timeout dut%0d: observed no accept, expected req%0d accepted", d, exp_k);
        end
        if (found) begin
            tests++;
            assert (k == exp_k) else begin
                fails++;
                $error("FAIL grant dut%0d: observed req%0d, expected req%0d", d, k, exp_k);
            end
            if (exp_cyc >= 0) begin
                tests++;
                assert (acc == exp_cyc) else begin
                    fails++;
                    $error("FAIL accept_cycle dut%0d: observed %0d, expected %0d", d, acc, exp_cyc);
                end
            end
            last_k[d] = exp_k;
            @(posedge clk);
            #1;
            val[d][k] = 1'b0;
        end else begin
            val[d] = 2'b00;
        end
    endtask

    task automatic check_req(input int d, input int k, input int acc);
        logic [1:0]  o = op[d][k];
        logic [15:0] g = gms[d][k];
        logic [15:0] r = rms[d][k];
        logic [15:0] y = yms[d][k];
        int n = n_cmds(o);
        int stp = gap_of(d) + 1;
        bit seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            #1;
            tests++;
            assert ({busy[d], rdy[d]} === 3'b100) else begin
                fails++;
                $error("FAIL busy_rdy dut%0d cyc%0d: observed busy/rdy=%b, expected 100", d, cyc, {busy[d], rdy[d]});
            end
            seen = (dq.size() != 0);
        end
        tests++;
        assert (seen && pq.size() == n) else begin
            fails++;
            $error("FAIL pulse_count dut%0d: observed %0d (done seen=%0d), expected %0d", d, pq.size(), seen, n);
        end
        for (int i = 0; i < n && pq.size() > 0; i++) begin
            pulse_t p = pq.pop_front();
            logic [18:0] e = exp_cmd(o, i, g, r, y);
            int ec = acc + 1 + i * stp;
            tests++;
            assert (p.d == d && p.cyc == ec && {p.t, p.dat} === e) else begin
                fails++;
                $error("FAIL cmd%0d dut%0d: observed cyc=%0d type=%0d data=%0h, expected cyc=%0d type=%0d data=%0h",
                       i, p.d, p.cyc, p.t, p.dat, ec, e[18:16], e[15:0]);
            end
        end
        pq.delete();
        if (dq.size() > 0) begin
            done_t q = dq.pop_front();
            int edc = done_cyc(d, o, acc);
            tests++;
            assert (q.d == d && q.cyc == edc && q.id === k[0]) else begin
                fails++;
                $error("FAIL done dut%0d: observed cyc=%0d id=%0d, expected cyc=%0d id=%0d", q.d, q.cyc, q.id, edc, k);
            end
        end
        dq.delete();
    endtask

    task automatic run_one(input int d, input int k);
        int kk, acc;
        val[d][k] = 1'b1;
        wait_accept(d, k, -1, kk, acc);
        if (acc != 0) check_req(d, k, acc);
    endtask

    // Two requests back to back; dly>0 raises the second one while busy.
    task automatic run_two(input int d, input int first, input int dly);
        int win, oth, kk, acc, acc2;
        if (dly == 0) begin
            val[d] = 2'b11;
            win = 1 - last_k[d];
        end else begin
            val[d][first] = 1'b1;
            win = first;
        end
        oth = 1 - win;
        wait_accept(d, win, -1, kk, acc);
        if (acc == 0) return;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
            val[d][oth] = 1'b1;
        end
        check_req(d, win, acc);
        wait_accept(d, oth, done_cyc(d, op[d][win], acc) + 1, kk, acc2);
        if (acc2 != 0) check_req(d, oth, acc2);
    endtask

    task automatic run_reset_mid(input int d);
        int kk, acc;
        pulse_t p;
        logic [18:0] e;
        set_req(d, 0, OP_RECONFIG, 16'd100, 16'd200, 16'd300);
        val[d][0] = 1'b1;
        wait_accept(d, 0, -1, kk, acc);
        for (int c = 0; c < 40 && pq.size() < 2; c++) begin
            @(negedge clk);
            #1;
        end
        tests++;
        assert (pq.size() == 2) else begin
            fails++;
            $error("FAIL pre_reset_pulses dut%0d: observed %0d, expected 2", d, pq.size());
        end
        rst_n[d] = 1'b0;
        #1;
        tests++;
        assert ({rdy[d], cval[d], ctype[d], cdata[d], busy[d], done[d], did[d]} === 25'd0) else begin
            fails++;
            $error("FAIL async_reset dut%0d: observed %h, expected 0", d,
                   {rdy[d], cval[d], ctype[d], cdata[d], busy[d], done[d], did[d]});
        end
        repeat (3) @(negedge clk);
        rst_n[d] = 1'b1;
        last_k[d] = 1;
        repeat (10) @(negedge clk);
        #1;
        tests++;
        assert (pq.size() == 2 && dq.size() == 0 && busy[d] === 1'b0) else begin
            fails++;
            $error("FAIL abandon dut%0d: observed pulses=%0d dones=%0d busy=%0d, expected 2/0/0", d, pq.size(), dq.size(), busy[d]);
        end
        for (int i = 0; i < 2 && pq.size() > 0; i++) begin
            p = pq.pop_front();
            e = exp_cmd(OP_RECONFIG, i, 16'd100, 16'd200, 16'd300);
            tests++;
            assert ({p.t, p.dat} === e) else begin
                fails++;
                $error("FAIL pre_reset_cmd%0d dut%0d: observed %0d/%0h, expected %0d/%0h", i, d, p.t, p.dat, e[18:16], e[15:0]);
            end
        end
        pq.delete();
        dq.delete();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; val[d] = '0; op[d] = '0; gms[d] = '0; rms[d] = '0; yms[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            assert ({rdy[d], cval[d], ctype[d], cdata[d], busy[d], done[d], did[d]} === 25'd0) else begin
                fails++;
                $error("FAIL reset_state dut%0d: observed %h, expected 0", d,
                       {rdy[d], cval[d], ctype[d], cdata[d], busy[d], done[d], did[d]});
            end
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Arbitration from reset, then tie after req0 was served alone.
        set_req(0, 0, OP_OFF, 16'd0, 16'd0, 16'd0);
        set_req(0, 1, OP_OFF, 16'd0, 16'd0, 16'd0);
        run_two(0, 0, 0);
        set_req(0, 0, OP_ON, 16'd0, 16'd0, 16'd0);
        run_one(0, 0);
        set_req(0, 0, OP_OFF, 16'd0, 16'd0, 16'd0);
        run_two(0, 0, 0);

        set_req(0, 0, OP_RECONFIG, 16'd10, 16'd20, 16'd5);
        run_one(0, 0);
        set_req(0, 1, OP_RECONFIG, 16'd0, 16'hFFFF, 16'd7);
        run_one(0, 1);

        set_req(0, 0, OP_RECONFIG, 16'd1, 16'd2, 16'd3);
        set_req(0, 1, OP_BLINK, 16'd0, 16'd0, 16'd0);
        run_two(0, 0, 3);
        set_req(0, 0, OP_ON, 16'd0, 16'd0, 16'd0);
        set_req(0, 1, OP_OFF, 16'd0, 16'd0, 16'd0);
        run_two(0, 0, 1);

        run_reset_mid(0);
        set_req(0, 1, OP_ON, 16'd0, 16'd0, 16'd0);
        run_one(0, 1);

        set_req(1, 1, OP_BLINK, 16'd0, 16'd0, 16'd0);
        run_one(1, 1);
        set_req(1, 1, OP_ON, 16'd0, 16'd0, 16'd0);
        run_one(1, 1);
        set_req(1, 1, OP_RECONFIG, 16'd300, 16'd0, 16'd40);
        run_one(1, 1);

        for (int it = 0; it < 20; it++) begin
            int d = int'($urandom % 2);
            int k = int'($urandom % 2);
            for (int j = 0; j < 2; j++)
                set_req(d, j, 2'($urandom), rnd_ms(), rnd_ms(), rnd_ms());
            if ($urandom % 3 == 0) run_two(d, k, int'($urandom % 2));
            else                   run_one(d, k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
